// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO registers and modelled multi-cycle latency.
// Optional build macro: MD_CANCEL_EN adds a Cancel input that aborts an in-flight op.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MdOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
`ifdef MD_CANCEL_EN
   input  logic        Cancel,
`endif
   output logic        Busy,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   md_op_e      op;
   logic        cancel_req;
   logic [CW-1:0] count;
   logic [31:0] stg_hi, stg_lo;
   logic        stg_wr;

   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, div_n, div_d, quo, rem;
   logic [31:0] res_hi, res_lo;
   logic        res_wr, is_arith;
   logic [CW-1:0] res_cycles;

   assign op = md_op_e'(MdOp);

`ifdef MD_CANCEL_EN
   assign cancel_req = Cancel;
`else
   assign cancel_req = 1'b0;
`endif

   // Signed product from sign-extended operands; the low 64 bits are exact.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // One unsigned divider shared by div/divu; div works on magnitudes and fixes signs after.
   assign abs_a = A[31] ? -A : A;
   assign abs_b = B[31] ? -B : B;
   assign div_n = (op == OP_DIV) ? abs_a : A;
   assign div_d = (op == OP_DIV) ? abs_b : B;
   assign quo   = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
   assign rem   = (div_d == 32'd0) ? 32'd0 : div_n % div_d;

   always_comb begin
      res_hi     = prod_s[63:32];
      res_lo     = prod_s[31:0];
      res_wr     = 1'b1;
      is_arith   = 1'b1;
      res_cycles = CW'(MULT_CYCLES);
      case (op)
         OP_MULT: ;
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            res_lo     = (A[31] ^ B[31]) ? -quo : quo;
            res_hi     = A[31] ? -rem : rem;
            res_wr     = (B != 32'd0);
            res_cycles = CW'(DIV_CYCLES);
         end
         OP_DIVU: begin
            res_lo     = quo;
            res_hi     = rem;
            res_wr     = (B != 32'd0);
            res_cycles = CW'(DIV_CYCLES);
         end
         default: is_arith = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Busy   <= 1'b0;
         Hi     <= 32'd0;
         Lo     <= 32'd0;
         count  <= '0;
         stg_hi <= 32'd0;
         stg_lo <= 32'd0;
         stg_wr <= 1'b0;
      end else if (cancel_req) begin
         Busy  <= 1'b0;
         count <= '0;
      end else if (Busy) begin
         // Start during an in-flight op is ignored entirely.
         count <= count - CW'(1);
         if (count == CW'(1)) begin
            Busy <= 1'b0;
            if (stg_wr) begin
               Hi <= stg_hi;
               Lo <= stg_lo;
            end
         end
      end else if (Start) begin
         if (is_arith) begin
            stg_hi <= res_hi;
            stg_lo <= res_lo;
            stg_wr <= res_wr;
            count  <= res_cycles;
            Busy   <= 1'b1;
         end else if (op == OP_MTHI) begin
            Hi <= A;
         end else if (op == OP_MTLO) begin
            Lo <= A;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: cycle-by-cycle compare against a timestamp model
// plus literal expectations for the hand-worked vectors.
module tb_mult_div_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic [2:0]  MdOp = 3'd0;
   logic [31:0] A = 32'd0, B = 32'd0;
`ifdef MD_CANCEL_EN
   logic        Cancel = 1'b0;
`endif
   logic        Busy;
   logic [31:0] Hi, Lo;

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MdOp(MdOp), .A(A), .B(B),
`ifdef MD_CANCEL_EN
      .Cancel(Cancel),
`endif
      .Busy(Busy), .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted op finishes at a cycle timestamp; busy means "now < finish".
   longint cyc = 0, done_at = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   bit p_wr = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc = 0; done_at = 0; m_hi = 0; m_lo = 0; p_wr = 0;
      end else begin
         bit was_busy;
         was_busy = (cyc < done_at);
         cyc++;
`ifdef MD_CANCEL_EN
         if (Cancel) begin
            done_at = cyc;
         end else
`endif
         if (was_busy) begin
            if (cyc == done_at && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
         end else if (Start) begin
            longint sp;
            longint unsigned up;
            int sa, sb;
            sa = int'(A); sb = int'(B);
            p_wr = 1;
            case (MdOp)
               3'd1: begin sp = longint'(sa) * longint'(sb); p_hi = sp[63:32]; p_lo = sp[31:0]; done_at = cyc + MC; end
               3'd2: begin up = longint'({32'd0, A}) * longint'({32'd0, B}); p_hi = up[63:32]; p_lo = up[31:0]; done_at = cyc + MC; end
               3'd3: begin
                  done_at = cyc + DC;
                  if (sb == 0) p_wr = 0;
                  else if (sa == int'(32'h8000_0000) && sb == -1) begin p_lo = 32'h8000_0000; p_hi = 0; end
                  else begin p_lo = sa / sb; p_hi = sa % sb; end
               end
               3'd4: begin
                  done_at = cyc + DC;
                  if (B == 0) p_wr = 0;
                  else begin p_lo = A / B; p_hi = A % B; end
               end
               3'd5: m_hi = A;
               3'd6: m_lo = A;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy", {31'd0, Busy}, {31'd0, (cyc < done_at)});
         chk("model_hi", Hi, m_hi);
         chk("model_lo", Lo, m_lo);
      end
   end

   // Called at a negedge; leaves the bench at the first negedge with Busy low.
   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int mode, output int n);
      Start = 1; MdOp = op; A = a; B = b;
      @(negedge clk);
      Start = 0; MdOp = 0; A = $urandom; B = $urandom;
      n = 0;
      while (Busy && n < 50) begin
         n++;
         if (mode == 1 && n == 2) begin Start = 1; MdOp = 3'd6; A = 32'hDEAD_BEEF; end
         if (mode == 1 && n == 3) begin MdOp = 3'd1; A = 32'h7; B = 32'h9; end
         if (mode == 1 && n == 4) begin Start = 0; MdOp = 0; end
`ifdef MD_CANCEL_EN
         if (mode == 2 && n == 4) Cancel = 1;
`endif
         @(negedge clk);
      end
`ifdef MD_CANCEL_EN
      Cancel = 0;
`endif
      Start = 0; MdOp = 0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      reset = 0;
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_hi", Hi, 32'd0);
      chk("reset_lo", Lo, 32'd0);
      chk_en = 1;

      run(3'd1, 32'hFFFF_FFFF, 32'd2, 0, n);
      chk("mult_cycles", n, MC);
      chk("mult_hi", Hi, 32'hFFFF_FFFF);
      chk("mult_lo", Lo, 32'hFFFF_FFFE);

      run(3'd2, 32'hFFFF_FFFF, 32'd2, 0, n);
      chk("multu_cycles", n, MC);
      chk("multu_hi", Hi, 32'h0000_0001);
      chk("multu_lo", Lo, 32'hFFFF_FFFE);

      run(3'd3, 32'hFFFF_FFF9, 32'd2, 0, n);
      chk("div_cycles", n, DC);
      chk("div_lo", Lo, 32'hFFFF_FFFD);
      chk("div_hi", Hi, 32'hFFFF_FFFF);

      run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, n);
      chk("divu_cycles", n, DC);
      chk("divu_lo", Lo, 32'h7FFF_FFFC);
      chk("divu_hi", Hi, 32'h0000_0001);

      run(3'd5, 32'h0000_1234, 32'd0, 0, n);
      chk("mthi_cycles", n, 0);
      chk("mthi_hi", Hi, 32'h0000_1234);
      run(3'd3, 32'h0000_0064, 32'd0, 1, n);
      chk("div0_cycles", n, DC);
      chk("div0_hi", Hi, 32'h0000_1234);
      chk("div0_lo", Lo, 32'h7FFF_FFFC);

      run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
      chk("divovf_lo", Lo, 32'h8000_0000);
      chk("divovf_hi", Hi, 32'h0000_0000);

      run(3'd1, 32'h8000_0000, 32'h8000_0000, 0, n);
      chk("mult_negneg_hi", Hi, 32'h4000_0000);
      chk("mult_negneg_lo", Lo, 32'h0000_0000);

      run(3'd6, 32'hCAFE_F00D, 32'd0, 0, n);
      chk("mtlo_lo", Lo, 32'hCAFE_F00D);
      run(3'd7, 32'h1111_1111, 32'd0, 0, n);
      chk("rsvd_hi", Hi, 32'h4000_0000);
      chk("rsvd_lo", Lo, 32'hCAFE_F00D);

      // Reset pulsed mid-cycle three cycles into a mult.
      Start = 1; MdOp = 3'd1; A = 32'd3; B = 32'd4;
      @(negedge clk);
      Start = 0; MdOp = 0;
      repeat (2) @(negedge clk);
      #2 reset = 1;
      #1;
      chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
      chk("rst_mid_hi", Hi, 32'd0);
      chk("rst_mid_lo", Lo, 32'd0);
      #1 reset = 0;
      repeat (10) @(negedge clk);
      chk("rst_after_hi", Hi, 32'd0);
      chk("rst_after_lo", Lo, 32'd0);

`ifdef MD_CANCEL_EN
      run(3'd5, 32'hAAAA_0001, 32'd0, 0, n);
      run(3'd3, 32'd9, 32'd3, 2, n);
      chk("cancel_cycles", n, 4);
      chk("cancel_hi", Hi, 32'hAAAA_0001);
      chk("cancel_lo", Lo, 32'd0);
`endif

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout actual=running required=done");
      $fatal(1);
   end
endmodule
